jzjpcc_writeback_stage: RTL and testbench

MEM/WB pipeline register and writeback formatter for the pipelined RV32I core. Takes the memory-stage result and raw load word, then selects, aligns and sign-extends the write data. Drives the regfile write port (rdAddr/rd/rdWriteEn) one cycle later, and also serves as the forwarding source for the execute stage. Keeps a 32-bit retired-instruction counter.

---
 rtl/jzjpcc_writeback_stage.sv | 110 +++++++++++
 tb/tb_jzjpcc_writeback_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_writeback_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | jzjpcc_writeback_stage: MEM/WB register, load formatter, retire count  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module jzjpcc_writeback_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  not_reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_write_en,
    input  logic [1:0]            mem_wb_sel,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_pc_plus4,
    input  logic [2:0]            mem_funct3,
    input  logic [XLEN-1:0]       mem_load_data,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd,
    output logic                  rd_write_en,
    output logic                  wb_valid,
    output logic [31:0]           retire_count
);

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_LINK = 2'b10;

    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [XLEN-1:0]       w_load_fmt;
    logic [XLEN-1:0]       w_wb_data;
    logic                  w_capture;

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [XLEN-1:0]       r_rd;
    logic                  r_write_flag;
    logic [31:0]           r_retire_count;

    always_comb begin
        case (mem_alu_result[1:0])
            2'd1:    w_byte = mem_load_data[15:8];
            2'd2:    w_byte = mem_load_data[23:16];
            2'd3:    w_byte = mem_load_data[31:24];
            default: w_byte = mem_load_data[7:0];
        endcase

        w_half = mem_alu_result[1] ? mem_load_data[31:16] : mem_load_data[15:0];

        // Unknown funct3 codes fall back to a full-word load.
        case (mem_funct3)
            c_LB:    w_load_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_LBU:   w_load_fmt = {{(XLEN-8){1'b0}}, w_byte};
            c_LH:    w_load_fmt = {{(XLEN-16){w_half[15]}}, w_half};
            c_LHU:   w_load_fmt = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_fmt = mem_load_data;
        endcase

        case (mem_wb_sel)
            c_SEL_LOAD: w_wb_data = w_load_fmt;
            c_SEL_LINK: w_wb_data = mem_pc_plus4;
            default:    w_wb_data = mem_alu_result;
        endcase
    end

    assign w_capture = !flush && !stall;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_valid        <= 1'b0;
            r_rd_addr      <= '0;
            r_rd           <= '0;
            r_write_flag   <= 1'b0;
            r_retire_count <= 32'd0;
        end else begin
            // Flush only kills the valid/write flags; address and data are don't-care when invalid.
            if (flush) begin
                r_valid      <= 1'b0;
                r_write_flag <= 1'b0;
            end else if (!stall) begin
                r_valid      <= mem_valid;
                r_rd_addr    <= mem_rd_addr;
                r_rd         <= w_wb_data;
                r_write_flag <= mem_rd_write_en;
            end

            if (w_capture && mem_valid) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    // Gating on x0 here keeps the zero register immune to writes.
    assign rd_write_en  = r_valid && r_write_flag && (r_rd_addr != '0);
    assign rd_addr      = r_rd_addr;
    assign rd           = r_rd;
    assign wb_valid     = r_valid;
    assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_writeback_stage.sv
`default_nettype none
// Testbench for jzjpcc_writeback_stage: directed cases plus randomized traffic vs. a reference model.
module tb_jzjpcc_writeback_stage;

    logic        clock;
    logic        not_reset;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_write_en;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc_plus4;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_load_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic        rd_write_en;
    logic        wb_valid;
    logic [31:0] retire_count;

    jzjpcc_writeback_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clock           (clock),
        .not_reset       (not_reset),
        .stall           (stall),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_write_en (mem_rd_write_en),
        .mem_wb_sel      (mem_wb_sel),
        .mem_alu_result  (mem_alu_result),
        .mem_pc_plus4    (mem_pc_plus4),
        .mem_funct3      (mem_funct3),
        .mem_load_data   (mem_load_data),
        .rd_addr         (rd_addr),
        .rd              (rd),
        .rd_write_en     (rd_write_en),
        .wb_valid        (wb_valid),
        .retire_count    (retire_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_we;
    logic [31:0] m_count;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * int'(off))) & 32'h0000_00FF;
        h = (word >> (16 * (int'(off) / 2))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_wb_data();
        if (mem_wb_sel == 2'b01) return ref_load(mem_load_data, mem_funct3, mem_alu_result[1:0]);
        if (mem_wb_sel == 2'b10) return mem_pc_plus4;
        return mem_alu_result;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_addr = '0; m_data = '0; m_we = 1'b0; m_count = '0;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_valid = 1'b0;
            m_we    = 1'b0;
        end else if (!stall) begin
            m_valid = mem_valid;
            m_addr  = mem_rd_addr;
            m_data  = ref_wb_data();
            m_we    = mem_rd_write_en;
            if (mem_valid) m_count = m_count + 32'd1;
        end
    endtask

    task automatic compare_all(input string tag);
        check_value({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, m_valid});
        check_value({tag, ".rd_write_en"}, {31'd0, rd_write_en},
                    {31'd0, m_valid && m_we && (m_addr != 5'd0)});
        check_value({tag, ".retire_count"}, retire_count, m_count);
        if (m_valid) begin
            check_value({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, m_addr});
            check_value({tag, ".rd"}, rd, m_data);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic we, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] ld);
        mem_valid = v; mem_rd_addr = a; mem_rd_write_en = we; mem_wb_sel = sel;
        mem_alu_result = alu; mem_pc_plus4 = pc; mem_funct3 = f3; mem_load_data = ld;
    endtask

    initial begin
        not_reset = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all("reset");
        check_value("reset.rd_addr", {27'd0, rd_addr}, 32'd0);
        check_value("reset.rd", rd, 32'd0);
        @(negedge clock);
        not_reset = 1'b1;

        // Basic ALU writeback
        drive(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'd2, 32'h0);
        tick("alu");
        check_value("alu.rd_const", rd, 32'h1234_5678);
        check_value("alu.count_const", retire_count, 32'd1);

        // Load formatting on word 0x80FF7F01
        drive(1'b1, 5'd7, 1'b1, 2'b01, 32'h0000_1001, 32'h0, 3'b000, 32'h80FF_7F01);
        tick("lb1");  check_value("lb1.const", rd, 32'h0000_007F);
        mem_alu_result = 32'h0000_1002;
        tick("lb2");  check_value("lb2.const", rd, 32'hFFFF_FFFF);
        mem_funct3 = 3'b100; mem_alu_result = 32'h0000_1003;
        tick("lbu3"); check_value("lbu3.const", rd, 32'h0000_0080);
        mem_funct3 = 3'b001; mem_alu_result = 32'h0000_1002;
        tick("lh2");  check_value("lh2.const", rd, 32'hFFFF_80FF);
        mem_funct3 = 3'b101; mem_alu_result = 32'h0000_1000;
        tick("lhu0"); check_value("lhu0.const", rd, 32'h0000_7F01);
        mem_funct3 = 3'b011; mem_alu_result = 32'h0000_1003;
        tick("lw_other"); check_value("lw_other.const", rd, 32'h80FF_7F01);

        // Link value and x0 destination
        drive(1'b1, 5'd1, 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0104, 3'd0, 32'h0);
        tick("link");  check_value("link.const", rd, 32'h0000_0104);
        mem_rd_addr = 5'd0;
        tick("link_x0");
        check_value("link_x0.we_const", {31'd0, rd_write_en}, 32'd0);
        check_value("link_x0.count_const", retire_count, 32'd9);
        mem_wb_sel = 2'b11; mem_rd_addr = 5'd3;
        tick("sel11"); check_value("sel11.const", rd, 32'hDEAD_BEEF);

        // Stall three cycles while MEM inputs churn
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 10), 1'b1, 2'b00, $urandom, $urandom, 3'd2, $urandom);
            tick("stall");
            check_value("stall.rd_const", rd, 32'hDEAD_BEEF);
        end
        flush = 1'b1;
        tick("stall_flush");
        check_value("stall_flush.valid_const", {31'd0, wb_valid}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Async reset between edges while a write is pending
        drive(1'b1, 5'd9, 1'b1, 2'b00, 32'hCAFE_0001, 32'h0, 3'd2, 32'h0);
        tick("pre_areset");
        check_value("pre_areset.we_const", {31'd0, rd_write_en}, 32'd1);
        #2;
        not_reset = 1'b0;
        model_reset();
        #1;
        check_value("areset.rd_write_en", {31'd0, rd_write_en}, 32'd0);
        check_value("areset.wb_valid", {31'd0, wb_valid}, 32'd0);
        check_value("areset.retire_count", retire_count, 32'd0);
        @(negedge clock);
        not_reset = 1'b1;

        // Counter wrap via a forced preload
        mem_valid = 1'b0;
        tick("bubble");
        @(negedge clock);
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        m_count = 32'hFFFF_FFFF;
        mem_valid = 1'b1;
        tick("wrap");
        check_value("wrap.const", retire_count, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            drive(1'($urandom), 5'($urandom_range(0, 31) < 4 ? 0 : $urandom),
                  1'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom), $urandom);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
